// File: rtl/ddr3_ctrl_core.sv
// rtl/ddr3_ctrl_core.sv - 256-bit line port to MIG-style DDR3 app interface bridge, one access at a time
// Optional read watchdog and err_o port: define DDR3_CTRL_TIMEOUT_EN.
module ddr3_ctrl_core #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  input  logic         we_i,
  input  logic         rd_i,
  output logic         ack_o,
  input  logic         init_calib_complete,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [255:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [31:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [255:0] app_rd_data,
`ifdef DDR3_CTRL_TIMEOUT_EN
  input  logic         app_rd_data_valid,
  output logic         err_o
`else
  input  logic         app_rd_data_valid
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, ACK} state_t;

  state_t        state, state_nx;
  logic [24:0]   addr_q;
  logic [255:0]  data_q;
  logic          cmd_done, wdf_done;
  logic          rd_timeout;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:25];

`ifdef DDR3_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  assign rd_timeout = (state == RD_WAIT) && !app_rd_data_valid &&
                      (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_o      = (state == ACK) && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == RD_WAIT) ? to_cnt + 1'b1 : '0;
      if (state == IDLE)
        err_q <= 1'b0;
      else if (rd_timeout)
        err_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rd_timeout = 1'b0;
`endif

  assign app_addr     = {addr_q, 3'b000};
  assign app_wdf_data = data_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  always_comb begin
    state_nx     = state;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_wdf_wren = 1'b0;
    ack_o        = 1'b0;
    case (state)
      IDLE: begin
        if (init_calib_complete && we_i)
          state_nx = WR;
        else if (init_calib_complete && rd_i)
          state_nx = RD_CMD;
      end
      WR: begin
        // Command and data channels complete independently, in any order.
        app_en       = !cmd_done;
        app_wdf_wren = !wdf_done;
        if ((cmd_done || app_rdy) && (wdf_done || app_wdf_rdy))
          state_nx = ACK;
      end
      RD_CMD: begin
        app_en  = 1'b1;
        app_cmd = 3'b001;
        if (app_rdy)
          state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (app_rd_data_valid || rd_timeout)
          state_nx = ACK;
      end
      ACK: begin
        ack_o    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_o   <= '0;
      cmd_done <= 1'b0;
      wdf_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        cmd_done <= 1'b0;
        wdf_done <= 1'b0;
      end else if (state == WR) begin
        if (app_en && app_rdy)
          cmd_done <= 1'b1;
        if (app_wdf_wren && app_wdf_rdy)
          wdf_done <= 1'b1;
      end
      if (state == RD_WAIT && app_rd_data_valid)
        data_o <= app_rd_data;
      else if (rd_timeout)
        data_o <= '1;
    end
  end

  // Request fields are captured only when leaving IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_q <= addr_i[24:0];
      data_q <= data_i;
    end
  end

endmodule

// File: tb/tb_ddr3_ctrl_core.sv
// tb/tb_ddr3_ctrl_core.sv - scoreboard bench for ddr3_ctrl_core with a behavioural MIG app model
module tb_ddr3_ctrl_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic [255:0] data_o;
  logic         we_i, rd_i, ack_o, init_calib_complete;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [255:0] app_wdf_data;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [31:0]  app_wdf_mask;
  logic [255:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;
`ifdef DDR3_CTRL_TIMEOUT_EN
  logic         err_o;
`endif

  ddr3_ctrl_core dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
`ifdef DDR3_CTRL_TIMEOUT_EN
    .app_rd_data_valid(app_rd_data_valid), .err_o(err_o)
`else
    .app_rd_data_valid(app_rd_data_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fake DDR3 IP: counts handshakes, stores writes, returns reads after rd_lat cycles.
  logic [255:0] mem [logic [27:0]];
  int           rd_lat = 10;
  bit           mute = 1'b0;
  int           cmd_cnt = 0, wr_cmds = 0, rd_cmds = 0, wdf_cnt = 0, valid_cnt = 0;
  int           rd_timer = 0;
  bit           rd_pending = 1'b0;
  logic [27:0]  rd_addr = '0;

  always @(posedge clk) begin
    app_rd_data_valid <= 1'b0;
    if (app_rd_data_valid) valid_cnt <= valid_cnt + 1;
    if (app_en && app_rdy) begin
      cmd_cnt <= cmd_cnt + 1;
      if (app_cmd == 3'b001) begin
        rd_cmds    <= rd_cmds + 1;
        rd_addr    <= app_addr;
        rd_timer   <= rd_lat;
        rd_pending <= 1'b1;
      end else begin
        wr_cmds <= wr_cmds + 1;
      end
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      mem[app_addr] = app_wdf_data;
      wdf_cnt <= wdf_cnt + 1;
    end
    if (rd_pending) begin
      if (rd_timer <= 1) begin
        rd_pending <= 1'b0;
        if (!mute) begin
          app_rd_data_valid <= 1'b1;
          app_rd_data       <= mem.exists(rd_addr) ? mem[rd_addr] : '0;
        end
      end else begin
        rd_timer <= rd_timer - 1;
      end
    end
  end

  typedef struct {
    logic [255:0] d;
    logic         e;
  } exp_t;
  exp_t         sb[$];
  logic [255:0] ref_mem [int];
  logic [255:0] exp_dout = '0;
  int           ack_cnt = 0;

  always @(negedge clk) begin
    if (ack_o) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        check("spurious_ack", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_data_o", data_o, e.d);
`ifdef DDR3_CTRL_TIMEOUT_EN
        check("ack_err_o", err_o, e.e);
`endif
      end
    end
  end

  task automatic push_write(input int a, input logic [255:0] d);
    exp_t e;
    ref_mem[a] = d;
    e.d = exp_dout;
    e.e = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_read(input int a);
    exp_t e;
    exp_dout = ref_mem.exists(a) ? ref_mem[a] : '0;
    e.d = exp_dout;
    e.e = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = ack_o;
    end
    if (!seen) check({tag, "_ack_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic access(input bit w, input int a, input logic [255:0] d, input int max);
    if (w) push_write(a, d);
    else   push_read(a);
    @(posedge clk); #1;
    addr_i = a; data_i = d; we_i = w; rd_i = !w;
    wait_ack(w ? "wr" : "rd", max);
    @(posedge clk); #1;
    we_i = 1'b0; rd_i = 1'b0;
  endtask

  bit bad;
  int c0, w0, a0, v0;

  initial begin
    rst = 1'b1; addr_i = '0; data_i = '0; we_i = 1'b0; rd_i = 1'b0;
    init_calib_complete = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack_o", ack_o, 1'b0);
    check("rst_data_o", data_o, '0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wdf_wren", app_wdf_wren, 1'b0);
    check("rst_wdf_end", app_wdf_end, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // calibration gate, then first write with latency check
    addr_i = 5; data_i = 5; we_i = 1'b1; bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      bad |= app_en | ack_o;
    end
    check("calib_gate", bad, 1'b0);
    push_write(5, 5);
    @(posedge clk); #1 init_calib_complete = 1'b1;
    @(posedge clk); @(negedge clk);
    check("wr_app_addr", app_addr, 28'h28);
    check("wr_app_cmd", app_cmd, 3'b000);
    check("wr_app_en", app_en, 1'b1);
    check("wr_wdf_data", app_wdf_data, 5);
    check("wr_wdf_wren", app_wdf_wren, 1'b1);
    check("wr_wdf_end", app_wdf_end, 1'b1);
    check("wr_wdf_mask", app_wdf_mask, 32'h0);
    @(negedge clk);
    check("wr_latency_ack", ack_o, 1'b1);
    @(posedge clk); #1 we_i = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", ack_o, 1'b0);

    // read back, data_o hold across a later write, second line
    rd_lat = 10;
    access(1'b0, 5, '0, 100);
    repeat (5) @(negedge clk);
    check("dout_hold", data_o, 5);
    access(1'b1, 9, 256'hABC, 100);
    check("dout_after_wr", data_o, 5);
    access(1'b0, 9, '0, 100);

    // backpressure: cmd stalled 7 cycles, data stalled 3 cycles
    c0 = cmd_cnt; w0 = wdf_cnt; a0 = ack_cnt; bad = 1'b0;
    push_write(12, 256'h1234_5678);
    @(posedge clk); #1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    addr_i = 12; data_i = 256'h1234_5678; we_i = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bad |= !app_en | ack_o;
      if (i < 3) bad |= !app_wdf_wren;
      @(posedge clk); #1;
      if (i == 2) app_wdf_rdy = 1'b1;
      if (i == 6) app_rdy = 1'b1;
    end
    check("bp_held", bad, 1'b0);
    wait_ack("bp", 20);
    @(posedge clk); #1 we_i = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_cmds", cmd_cnt - c0, 1);
    check("bp_wdf", wdf_cnt - w0, 1);
    check("bp_acks", ack_cnt - a0, 1);

    // we_i and rd_i together: write first, then the held read
    w0 = wr_cmds; c0 = rd_cmds;
    push_write(7, 256'h77);
    push_read(7);
    @(posedge clk); #1;
    addr_i = 7; data_i = 256'h77; we_i = 1'b1; rd_i = 1'b1;
    wait_ack("both_wr", 20);
    check("both_first_is_wr", wr_cmds - w0, 1);
    check("both_no_rd_yet", rd_cmds - c0, 0);
    @(posedge clk); #1 we_i = 1'b0;
    wait_ack("both_rd", 100);
    @(posedge clk); #1 rd_i = 1'b0;
    check("both_rd_cmds", rd_cmds - c0, 1);

    // reset during RD_WAIT, then the late response arrives
    rd_lat = 20; a0 = ack_cnt; v0 = valid_cnt;
    @(posedge clk); #1;
    addr_i = 7; rd_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; rd_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_dout = '0;
    repeat (30) @(negedge clk);
    check("late_valid_seen", valid_cnt - v0, 1);
    check("late_dout", data_o, '0);
    check("late_no_ack", ack_cnt - a0, 0);

`ifdef DDR3_CTRL_TIMEOUT_EN
    begin
      exp_t e;
      mute = 1'b1;
      e.d = '1; e.e = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      addr_i = 5; rd_i = 1'b1;
      wait_ack("timeout", 1200);
      @(posedge clk); #1 rd_i = 1'b0;
      @(negedge clk);
      check("timeout_err_clear", err_o, 1'b0);
      mute = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
